// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch squash,
// multi-cycle mult/div hold, plus a saturating count of cycles with the PC frozen.
module pipeline_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 4,
    parameter int STALL_W  = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [4:0]         d_rs,
    input  logic [4:0]         d_rt,
    input  logic               d_usesRs,
    input  logic               d_usesRt,
    input  logic               e_memRead,
    input  logic               e_writeBack,
    input  logic [4:0]         e_writeReg,
    input  logic               e_multStart,
    input  logic               e_branchTaken,
    output logic               pc_en,
    output logic               fd_en,
    output logic               fd_flush,
    output logic               de_en,
    output logic               de_flush,
    output logic               em_flush,
    output logic               busy,
    output logic [STALL_W-1:0] stall_cycles,
    output logic               dbg_state_o
);

    typedef enum logic {RUN = 1'b0, MULT_WAIT = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULT_LAT - 2);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STALL_W-1:0] stall_q;
    logic               mult_stall;
    logic               load_use;

    assign mult_stall = (state_q == RUN && e_multStart) ||
                        (state_q == MULT_WAIT && cnt_q != '0);

    // A load targeting $0 never produces a value anyone can depend on.
    assign load_use = e_memRead && e_writeBack && (e_writeReg != 5'd0) &&
                      ((d_usesRs && d_rs == e_writeReg) || (d_usesRt && d_rt == e_writeReg));

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        de_en    = 1'b1;
        de_flush = 1'b0;
        em_flush = 1'b0;
        busy     = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (!Rst_n) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else if (mult_stall) begin
            // ID/EX keeps the mult in EX while EX/MEM receives bubbles.
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_flush = 1'b1;
            busy     = 1'b1;
            if (state_q == RUN) begin
                state_d = MULT_WAIT;
                cnt_d   = CNT_INIT;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (state_q == MULT_WAIT) begin
            // Release cycle: the mult moves to MEM; a still-high e_multStart is the same mult.
            state_d = RUN;
        end else if (e_branchTaken) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en && stall_q != '1) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a vector table on the default instance, plus hand sequences for
// a short-latency mult, reset during a mult wait, and counter saturation on a narrow counter.
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        mr;
        logic        wb;
        logic [4:0]  wr;
        logic        ms;
        logic        bt;
        logic [6:0]  ctl;
        logic [15:0] cnt;
    } vec_t;

    // Control field order: {pc_en, fd_en, fd_flush, de_en, de_flush, em_flush, busy}
    localparam logic [6:0] DEF = 7'b1101000;
    localparam logic [6:0] LU  = 7'b0001100;
    localparam logic [6:0] BR  = 7'b1111100;
    localparam logic [6:0] MS  = 7'b0000011;
    localparam logic [6:0] RST = 7'b0010110;

    localparam int NV = 20;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [4:0]  d_rs, d_rt, e_writeReg;
    logic        d_usesRs, d_usesRt, e_memRead, e_writeBack, e_multStart, e_branchTaken;

    logic        pc_a, fe_a, ff_a, de_a, df_a, em_a, bz_a, st_a;
    logic        pc_b, fe_b, ff_b, de_b, df_b, em_b, bz_b, st_b;
    logic        pc_c, fe_c, ff_c, de_c, df_c, em_c, bz_c, st_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic [22:0] act_a, act_b, act_c;

    logic [24:0] exp_q[$];
    vec_t        tbl[NV];
    string       cur_tag;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl u_a (
        .Clk(Clk), .Rst_n(Rst_n), .d_rs(d_rs), .d_rt(d_rt), .d_usesRs(d_usesRs), .d_usesRt(d_usesRt),
        .e_memRead(e_memRead), .e_writeBack(e_writeBack), .e_writeReg(e_writeReg),
        .e_multStart(e_multStart), .e_branchTaken(e_branchTaken),
        .pc_en(pc_a), .fd_en(fe_a), .fd_flush(ff_a), .de_en(de_a), .de_flush(df_a),
        .em_flush(em_a), .busy(bz_a), .stall_cycles(cnt_a), .dbg_state_o(st_a));

    pipeline_hazard_ctrl #(.MULT_LAT(2)) u_b (
        .Clk(Clk), .Rst_n(Rst_n), .d_rs(d_rs), .d_rt(d_rt), .d_usesRs(d_usesRs), .d_usesRt(d_usesRt),
        .e_memRead(e_memRead), .e_writeBack(e_writeBack), .e_writeReg(e_writeReg),
        .e_multStart(e_multStart), .e_branchTaken(e_branchTaken),
        .pc_en(pc_b), .fd_en(fe_b), .fd_flush(ff_b), .de_en(de_b), .de_flush(df_b),
        .em_flush(em_b), .busy(bz_b), .stall_cycles(cnt_b), .dbg_state_o(st_b));

    pipeline_hazard_ctrl #(.STALL_W(4)) u_c (
        .Clk(Clk), .Rst_n(Rst_n), .d_rs(d_rs), .d_rt(d_rt), .d_usesRs(d_usesRs), .d_usesRt(d_usesRt),
        .e_memRead(e_memRead), .e_writeBack(e_writeBack), .e_writeReg(e_writeReg),
        .e_multStart(e_multStart), .e_branchTaken(e_branchTaken),
        .pc_en(pc_c), .fd_en(fe_c), .fd_flush(ff_c), .de_en(de_c), .de_flush(df_c),
        .em_flush(em_c), .busy(bz_c), .stall_cycles(cnt_c), .dbg_state_o(st_c));

    assign act_a = {pc_a, fe_a, ff_a, de_a, df_a, em_a, bz_a, cnt_a};
    assign act_b = {pc_b, fe_b, ff_b, de_b, df_b, em_b, bz_b, cnt_b};
    assign act_c = {pc_c, fe_c, ff_c, de_c, df_c, em_c, bz_c, 12'd0, cnt_c};

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic mr, input logic wb,
                                input logic [4:0] wr, input logic ms, input logic bt,
                                input logic [6:0] ctl, input logic [15:0] cnt);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr; v.wb = wb;
        v.wr = wr; v.ms = ms; v.bt = bt; v.ctl = ctl; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        d_rs = v.rs; d_rt = v.rt; d_usesRs = v.urs; d_usesRt = v.urt;
        e_memRead = v.mr; e_writeBack = v.wb; e_writeReg = v.wr;
        e_multStart = v.ms; e_branchTaken = v.bt;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0));
    endtask

    // sel: 0 = default instance, 1 = MULT_LAT=2, 2 = STALL_W=4
    task automatic push(input logic [1:0] sel, input logic [6:0] ctl, input logic [15:0] cnt);
        exp_q.push_back({sel, ctl, cnt});
    endtask

    task automatic check_all();
        logic [24:0] e;
        logic [22:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e[24:23])
                2'd0:    act = act_a;
                2'd1:    act = act_b;
                default: act = act_c;
            endcase
            n_vec++;
            if (act !== e[22:0]) begin
                n_err++;
                $display("FAIL %s dut%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                         cur_tag, e[24:23], act[22:16], act[15:0], e[22:16], e[15:0]);
            end
        end
    endtask

    task automatic step();
        @(negedge Clk);
        check_all();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        Rst_n = 1'b0;
        cur_tag = "reset";
        @(negedge Clk);
        push(0, RST, 0);
        push(2, RST, 0);
        check_all();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        tbl[1]  = mk(8, 0, 1, 0, 1, 1, 8, 0, 0, LU,  0);
        tbl[2]  = mk(8, 0, 1, 0, 0, 0, 0, 0, 0, DEF, 1);
        tbl[3]  = mk(0, 0, 1, 0, 1, 1, 0, 0, 0, DEF, 1);
        tbl[4]  = mk(8, 8, 0, 0, 1, 1, 8, 0, 0, DEF, 1);
        tbl[5]  = mk(3, 9, 1, 1, 1, 1, 9, 0, 0, LU,  1);
        tbl[6]  = mk(3, 9, 1, 1, 1, 0, 9, 0, 0, DEF, 2);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, BR,  2);
        tbl[8]  = mk(8, 0, 1, 0, 1, 1, 8, 0, 1, BR,  2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MS,  2);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MS,  3);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MS,  4);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF, 5);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 5);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, MS,  5);
        tbl[16] = mk(8, 0, 1, 0, 1, 1, 8, 1, 0, MS,  6);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MS,  7);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, DEF, 8);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 8);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            drive(tbl[i]);
            push(0, tbl[i].ctl, tbl[i].cnt);
            step();
        end

        // Short-latency mult: one stall cycle, then release with e_multStart still high.
        do_reset();
        cur_tag = "mult_lat2";
        e_multStart = 1'b1;
        push(1, MS, 0);
        step();
        push(1, DEF, 1);
        step();
        drive_idle();
        push(1, DEF, 1);
        step();

        // Reset during the second stall cycle of a mult aborts the wait.
        do_reset();
        cur_tag = "mult_reset";
        e_multStart = 1'b1;
        push(0, MS, 0);
        step();
        push(0, MS, 1);
        @(negedge Clk);
        check_all();
        #2;
        Rst_n = 1'b0;
        #1;
        cur_tag = "mid_reset";
        push(0, RST, 0);
        check_all();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        drive_idle();
        cur_tag = "post_reset";
        push(0, DEF, 0);
        step();
        push(0, DEF, 0);
        step();
        e_multStart = 1'b1;
        push(0, MS, 0);
        step();

        // 20 back-to-back load-use stalls: narrow counter saturates, wide one does not.
        do_reset();
        cur_tag = "saturate";
        drive(mk(5, 0, 1, 0, 1, 1, 5, 0, 0, LU, 0));
        for (int i = 0; i < 20; i++) begin
            push(0, LU, 16'(i));
            push(2, LU, (i > 15) ? 16'd15 : 16'(i));
            step();
        end
        drive_idle();
        push(0, DEF, 20);
        push(2, DEF, 15);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
